// File: rtl/fifo_bh_pkg.sv
// -----------------------------------------------------------------------------
// fifo_bh_pkg
// Shared definitions for the parametrised show-ahead FIFO.
//   DEF_DATA_WIDTH : default entry width
//   DEF_DEPTH      : default number of entries
//   ptr_w(depth)   : pointer width, address bits plus one wrap bit
// -----------------------------------------------------------------------------
package fifo_bh_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;

  // One extra bit beyond the address lets full and empty be told apart
  // when the address bits of the two pointers are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_bh_ptr_ctr.sv
// -----------------------------------------------------------------------------
// fifo_bh_ptr_ctr
// Wrap-bit pointer counter. It counts up by one on each enabled clock edge and
// wraps naturally at 2**W. The FIFO uses one for the write pointer and one for
// the read pointer.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous, active-low reset (pointer -> 0)
//   en      : advance the pointer by one at the next rising edge
//   ptr     : current pointer value
// -----------------------------------------------------------------------------
module fifo_bh_ptr_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_bh_param_depth.sv
// -----------------------------------------------------------------------------
// fifo_bh_param_depth
// Single-clock show-ahead FIFO with power-of-two depth. It provides an
// occupancy count, almost-full and almost-empty thresholds, and protected
// push and pop.
//
// Handshake: push is wren_i with no ready. A push is accepted when the FIFO is
// not full, or when it is full and a pop happens in the same cycle. Pop is
// rden_i. A pop is accepted only when the FIFO is non-empty, so a pop issued
// with a push into an empty FIFO is dropped. A dropped request changes no
// state except the sticky error flags.
//
// Optional feature macro: FIFO_BH_ERR_FLAGS_EN. When it is defined,
// overflow_o and underflow_o are sticky error registers that err_clr_i clears.
// When it is undefined, both outputs are tied to 0 and err_clr_i is ignored.
//
// Ports:
//   clk, reset_n          : clock (rising edge); asynchronous active-low reset
//   wren_i, wdata_i       : push request and push data
//   rden_i, rdata_o       : pop request; head entry (show-ahead)
//   full_o, empty_o       : count == DEPTH, count == 0
//   afull_o, aempty_o     : count >= AFULL_THRESH, count <= AEMPTY_THRESH
//   count_o               : occupancy, 0..DEPTH
//   err_clr_i             : clears the sticky error flags
//   overflow_o            : sticky; a push was dropped
//   underflow_o           : sticky; a pop was dropped
// -----------------------------------------------------------------------------
module fifo_bh_param_depth
  import fifo_bh_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wren_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       rden_i,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       afull_o,
  output logic                       aempty_o,
  output logic [ptr_w(DEPTH)-1:0]    count_o,
  input  logic                       err_clr_i,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  // Elaboration-time parameter checks
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_bh_param_depth: DEPTH must be a power of two >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
    $error("fifo_bh_param_depth: AFULL_THRESH must be in 1..DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
    $error("fifo_bh_param_depth: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         wrptr;
  logic [PW-1:0]         rdptr;
  logic [PW-1:0]         count;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Flags come directly from the registered pointers.
  assign full_o  = (wrptr[AW-1:0] == rdptr[AW-1:0]) && (wrptr[AW] != rdptr[AW]);
  assign empty_o = (wrptr == rdptr);

  // When the FIFO is full, a push is still accepted if a pop frees the head
  // slot in the same cycle.
  assign push_ok = wren_i && (!full_o || rden_i);
  assign pop_ok  = rden_i && !empty_o;

  fifo_bh_ptr_ctr #(.W(PW)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (push_ok),
    .ptr     (wrptr)
  );

  fifo_bh_ptr_ctr #(.W(PW)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pop_ok),
    .ptr     (rdptr)
  );

  // Storage clears on reset, so a freshly reset FIFO shows zero at its head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wrptr[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem[rdptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count + PW'(push_ok) - PW'(pop_ok);
    end
  end

  assign count_o  = count;
  assign afull_o  = (count >= AFULL_C);
  assign aempty_o = (count <= AEMPTY_C);

`ifdef FIFO_BH_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // A drop in the same cycle as a clear takes priority, so the flag stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wren_i && !push_ok) begin
        overflow <= 1'b1;
      end else if (err_clr_i) begin
        overflow <= 1'b0;
      end
      if (rden_i && !pop_ok) begin
        underflow <= 1'b1;
      end else if (err_clr_i) begin
        underflow <= 1'b0;
      end
    end
  end

  assign overflow_o  = overflow;
  assign underflow_o = underflow;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule
